// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
// Purpose : Bundles the command/response handshake and the APB bus signals of
//           apb_master into one interface.
// Modports:
//   master - view used by apb_master (drives cmd_ready, rsp_*, P* outputs).
//   slave  - opposite view, for the command source / APB slave side.
// Signals :
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command handshake
//   rsp_valid/rsp_rdata/rsp_err                      - transfer response
//   PSEL_S1/PSEL_S2/PENABLE/PWRITE/PADDR/PWDATA      - APB request
//   PRDATA/PREADY/PSLVERR                            - APB completion
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface apb_master_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL_S1;
    logic                  PSEL_S2;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL_S1, PSEL_S2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL_S1, PSEL_S2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Purpose : Converts a valid/ready command stream into APB transfers towards
//           two slaves, decoded on the address MSB (0 -> slave 1, 1 -> slave 2),
//           and returns a one-cycle response pulse per completed transfer.
//           Back-to-back commands skip IDLE: a command presented on the cycle
//           a transfer completes goes straight into SETUP.
// Ports   :
//   PCLK   - sole clock, rising edge
//   PRESET - asynchronous active-high reset; aborts any transfer silently
//   bus    - apb_master_if.master: command handshake, response, APB signals
// Options :
//   APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees PREADY low
//                           for TIMEOUT_CYCLES cycles is ended with an error
//                           response. When undefined, ACCESS waits forever.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module apb_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_busy;

    // Transfer completes normally only when the slave answers in ACCESS.
    assign w_done = (r_state == ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Cleared while in SETUP so it starts at zero on ACCESS entry; counts
    // every ACCESS cycle in which the slave is still stalling.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !bus.PREADY) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires on the stalled cycle that would make the count reach the limit,
    // so exactly TIMEOUT_CYCLES stalled ACCESS cycles are seen on the bus.
    assign w_timeout = (r_state == ACCESS) && !bus.PREADY &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    // Completion cycle doubles as an accept slot so a queued
                    // command can follow without an IDLE bubble.
                    w_cmd_ready = 1'b1;
                    w_state_nxt = bus.cmd_valid ? SETUP : IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = w_cmd_ready && bus.cmd_valid;

    // Request registers: loaded on accept, then held untouched through
    // SETUP and every stalled ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
        end
    end

    // Response registers: one-cycle pulse after completion or timeout.
    // Read data is captured only on normal read completions, so writes and
    // timeouts leave the last read value visible.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done || w_timeout;
            if (w_done) begin
                r_rsp_err <= bus.PSLVERR;
                if (!r_pwrite) begin
                    r_rsp_rdata <= bus.PRDATA;
                end
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    // Select and enable are pure state decodes, so reset drops them at once.
    assign w_busy = (r_state == SETUP) || (r_state == ACCESS);

    assign bus.PSEL_S1   = w_busy && !r_paddr[ADDR_WIDTH-1];
    assign bus.PSEL_S2   = w_busy &&  r_paddr[ADDR_WIDTH-1];
    assign bus.PENABLE   = (r_state == ACCESS);
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

    // IDLE is the reset state, so ready must be masked while reset is held.
    assign bus.cmd_ready = w_cmd_ready && !PRESET;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
`timescale 1ns/1ps

module tb_apb_master;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int TMO_CYC = 8;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wait_n;
        logic [DW-1:0] rdata;
        logic          err;
    } xfer_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
    } rsp_t;

    xfer_t slv_q[$];
    rsp_t  exp_q[$];
    int    rsp_cyc[$];

    xfer_t         cur;
    int            s_cnt;
    int            acc_cnt;
    int            cyc;
    logic          prev_rsp;
    logic [AW-1:0] snap_addr;
    logic          snap_wr;
    logic [DW-1:0] snap_wdata;
    logic          snap_s2;
    logic [DW-1:0] last_rd;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met", name);
    endfunction

    // APB slave model: pops one transfer description per SETUP phase and
    // answers after wait_n stalled ACCESS cycles. Junk is driven on
    // PRDATA/PSLVERR while stalling.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = '0;
            end else if ((bus.PSEL_S1 || bus.PSEL_S2) && !bus.PENABLE) begin
                if (slv_q.size() == 0) begin
                    fail("unexpected_setup");
                end else begin
                    cur = slv_q.pop_front();
                end
                s_cnt       = 0;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = 32'hBAD0_0000;
            end else if (bus.PENABLE) begin
                if (s_cnt >= cur.wait_n) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = cur.rdata;
                    bus.PSLVERR = cur.err;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 32'hBAD0_0000 | 32'(s_cnt);
                    bus.PSLVERR = ~cur.err;
                end
                s_cnt++;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = 32'hBAD0_0000;
            end
        end
    end

    // Monitor: compares each response pulse against the scoreboard and
    // checks the APB request phases against the issued command.
    initial begin
        cyc      = 0;
        acc_cnt  = 0;
        prev_rsp = 1'b0;
        forever begin
            rsp_t e;
            @(negedge PCLK);
            #1;
            cyc++;
            if (PRESET) begin
                prev_rsp = 1'b0;
            end else begin
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        fail("spurious_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        chk("access_cycles", 32'(acc_cnt), 32'(e.acc));
                    end
                    if (prev_rsp) fail("rsp_consecutive");
                    rsp_cyc.push_back(cyc);
                end
                prev_rsp = bus.rsp_valid;
                if (bus.PSEL_S1 && bus.PSEL_S2) fail("psel_both_high");
                if ((bus.PSEL_S1 || bus.PSEL_S2) && !bus.PENABLE) begin
                    acc_cnt = 0;
                    chk("setup_paddr", 32'(bus.PADDR), 32'(cur.addr));
                    chk("setup_pwrite", 32'(bus.PWRITE), 32'(cur.wr));
                    chk("setup_pwdata", bus.PWDATA, cur.wdata);
                    chk("setup_psel_s2", 32'(bus.PSEL_S2), 32'(cur.addr[AW-1]));
                    snap_addr  = bus.PADDR;
                    snap_wr    = bus.PWRITE;
                    snap_wdata = bus.PWDATA;
                    snap_s2    = bus.PSEL_S2;
                end else if (bus.PENABLE) begin
                    acc_cnt++;
                    if (!(bus.PSEL_S1 || bus.PSEL_S2)) fail("penable_without_psel");
                    chk("access_paddr_stable", 32'(bus.PADDR), 32'(snap_addr));
                    chk("access_pwrite_stable", 32'(bus.PWRITE), 32'(snap_wr));
                    chk("access_pwdata_stable", bus.PWDATA, snap_wdata);
                    chk("access_psel_s2_stable", 32'(bus.PSEL_S2), 32'(snap_s2));
                end
            end
        end
    end

    // Presents one command, pushes the slave behaviour and the expected
    // response, and returns just after the accepting edge (in SETUP).
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int wait_n,
                         input logic [DW-1:0] rdata, input logic err,
                         input bit want_rsp);
        xfer_t x;
        rsp_t  r;
        bit    got;
        x = '{wr, addr, wdata, wait_n, rdata, err};
        slv_q.push_back(x);
        r.err   = err;
        r.acc   = wait_n + 1;
        r.rdata = wr ? last_rd : rdata;
`ifdef APB_MASTER_TIMEOUT_EN
        if (wait_n >= TMO_CYC) begin
            r.err   = 1'b1;
            r.acc   = TMO_CYC;
            r.rdata = last_rd;
        end
`endif
        if (want_rsp) begin
            exp_q.push_back(r);
            last_rd = r.rdata;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge PCLK);
            #1;
            if (bus.cmd_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            fail("accept_timeout");
        end else begin
            @(posedge PCLK);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge PCLK);
        if (exp_q.size() != 0) begin
            fail("drain_timeout");
            exp_q.delete();
        end
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_psel_s1"}, 32'(bus.PSEL_S1), 32'd0);
        chk({p, "_psel_s2"}, 32'(bus.PSEL_S2), 32'd0);
        chk({p, "_penable"}, 32'(bus.PENABLE), 32'd0);
        chk({p, "_pwrite"}, 32'(bus.PWRITE), 32'd0);
        chk({p, "_paddr"}, 32'(bus.PADDR), 32'd0);
        chk({p, "_pwdata"}, bus.PWDATA, 32'd0);
        chk({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({p, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({p, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (bad=%0d)", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        last_rd       = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_outputs("por");
        PRESET = 1'b0;
        #1;
        chk("por_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;

        // Single write, zero wait: exact phase timing.
        issue(1'b1, 10'h003, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b1);
        chk("wr_setup_psel_s1", 32'(bus.PSEL_S1), 32'd1);
        chk("wr_setup_psel_s2", 32'(bus.PSEL_S2), 32'd0);
        chk("wr_setup_penable", 32'(bus.PENABLE), 32'd0);
        @(posedge PCLK);
        #1;
        chk("wr_access_psel_s1", 32'(bus.PSEL_S1), 32'd1);
        chk("wr_access_penable", 32'(bus.PENABLE), 32'd1);
        chk("wr_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge PCLK);
        #1;
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_psel_s1", 32'(bus.PSEL_S1), 32'd0);
        chk("wr_rsp_penable", 32'(bus.PENABLE), 32'd0);
        wait_drain();

        // Read from slave 2 with four stalled ACCESS cycles.
        issue(1'b0, 10'h201, 32'h0, 4, 32'h12345678, 1'b0, 1'b1);
        chk("rd_setup_psel_s1", 32'(bus.PSEL_S1), 32'd0);
        chk("rd_setup_psel_s2", 32'(bus.PSEL_S2), 32'd1);
        wait_drain();
        chk("rd_rdata_held", bus.rsp_rdata, 32'h12345678);

        // Back-to-back write then read with cmd_valid kept high.
        rsp_cyc.delete();
        issue(1'b1, 10'h000, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 10'h001, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b1);
        wait_drain();
        if (rsp_cyc.size() == 2) chk("b2b_rsp_gap", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd2);
        else fail("b2b_rsp_count");

        // Read with slave error, then an erroring write that must keep rdata.
        issue(1'b0, 10'h010, 32'h0, 1, 32'h0BADF00D, 1'b1, 1'b1);
        wait_drain();
        issue(1'b1, 10'h3FF, 32'h13579BDF, 2, 32'h0, 1'b1, 1'b1);
        wait_drain();

        // Reset pulse in the middle of a stalled ACCESS phase.
        issue(1'b0, 10'h155, 32'h0, 20, 32'h77777777, 1'b0, 1'b0);
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        chk("mid_access_penable", 32'(bus.PENABLE), 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge PCLK);
        @(posedge PCLK);
        #3;
        PRESET  = 1'b0;
        last_rd = '0;
        #1;
        chk("mid_rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_release_penable", 32'(bus.PENABLE), 32'd0);
        repeat (5) @(posedge PCLK);
        #1;

        // Normal operation resumes after the aborted transfer.
        issue(1'b0, 10'h2AA, 32'h0, 1, 32'h600DCAFE, 1'b0, 1'b1);
        wait_drain();

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never answers: error response after TMO_CYC ACCESS cycles.
        issue(1'b0, 10'h201, 32'h0, 1000, 32'hFFFF0000, 1'b0, 1'b1);
        wait_drain();
        chk("tmo_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("tmo_idle_psel_s1", 32'(bus.PSEL_S1), 32'd0);
        chk("tmo_idle_psel_s2", 32'(bus.PSEL_S2), 32'd0);
        chk("tmo_idle_penable", 32'(bus.PENABLE), 32'd0);
`endif

        repeat (3) @(posedge PCLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS cycles with PREADY low (used only with timeout enabled).
REQ-004 SHALL have port PCLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port PRESET  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  target address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse, transfer complete.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid on reads.
REQ-013 SHALL have port rsp_err  output  1  error flag, valid with rsp_valid.
REQ-014 SHALL have port PSEL_S1  output  1  select, slave 1 (PADDR MSB = 0).
REQ-015 SHALL have port PSEL_S2  output  1  select, slave 2 (PADDR MSB = 1).
REQ-016 SHALL have port PENABLE  output  1  APB access phase.
REQ-017 SHALL have port PWRITE  output  1  APB direction.
REQ-018 SHALL have port PADDR  output  ADDR_WIDTH  APB address.
REQ-019 SHALL have port PWDATA  output  DATA_WIDTH  APB write data.
REQ-020 SHALL have port PRDATA  input  DATA_WIDTH  APB read data.
REQ-021 SHALL have port PREADY  input  1  slave ready.
REQ-022 SHALL have port PSLVERR  input  1  slave error; tie 0 if slave lacks it.

Function
REQ-023 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-024 cmd_ready SHALL be high only in IDLE, or in ACCESS on the cycle PREADY=1 completes the transfer.
REQ-025 On accept: cmd_write/addr/wdata registered into PWRITE/PADDR/PWDATA; next state SETUP.
REQ-026 SETUP: exactly one PSEL_Sx high per PADDR[ADDR_WIDTH-1], PENABLE=0; next state ACCESS unconditionally.
REQ-027 ACCESS: same PSEL_Sx, PENABLE=1; PADDR/PWRITE/PWDATA/PSEL held stable while PREADY=0.
REQ-028 ACCESS with PREADY=1: next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA on reads (unchanged on writes).
REQ-029 Completion with cmd_valid=1 in same cycle: accept new command, go directly to SETUP (back-to-back, no IDLE cycle); else IDLE with PSEL/PENABLE low.
REQ-030 Minimum transfer latency: accept edge to rsp_valid = 3 cycles (SETUP, ACCESS, response).
REQ-031 rsp_valid SHALL never assert for two consecutive cycles of one transfer; no response without a prior accept.
REQ-032 cmd_valid in SETUP or ACCESS-with-PREADY=0 SHALL be ignored (not accepted, no side effect).

Reset
REQ-033 PRESET high SHALL immediately force IDLE, PSEL_S1=PSEL_S2=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=rsp_err=0, rsp_rdata=0, cmd_ready=0 while asserted.
REQ-034 Reset mid-transfer SHALL abort silently (no rsp_valid); cmd_ready=1 first cycle after release.

Configuration
REQ-035 Macro APB_MASTER_TIMEOUT_EN defined: counter clears on ACCESS entry, increments per ACCESS cycle with PREADY=0; reaching TIMEOUT_CYCLES ends transfer -> rsp_valid=1, rsp_err=1, rsp_rdata unchanged, PSEL/PENABLE dropped, next IDLE.
REQ-036 Macro undefined: no counter; ACCESS waits indefinitely for PREADY.

Verification
REQ-037 Write 0x3 data 0xDEADBEEF, PREADY=1 -> PSEL_S1 2 cycles, PENABLE 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-038 Read 0x201 (MSB=1), PREADY low 4 ACCESS cycles, PRDATA=0x12345678 -> PSEL_S2 only, signals stable, rsp_rdata=0x12345678.
REQ-039 Back-to-back write 0x0 then read 0x1 with cmd_valid held -> second SETUP immediately follows first ACCESS; two rsp_valid pulses 2 cycles apart.
REQ-040 Read with PSLVERR=1 at PREADY -> rsp_valid=1, rsp_err=1.
REQ-041 PRESET pulsed during ACCESS -> all outputs 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
REQ-042 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> rsp_err=1 after 8 ACCESS cycles, PSEL low, FSM IDLE.
